// File: rtl/lane_align_pkg.sv
// -----------------------------------------------------------------------------
// lane_align_pkg
// Shared types and width helpers for the DDR lane word aligner.
//   align_state_t  : training FSM states
//   off_width()    : width of a per-lane slip offset for a given word width
//   phase_width()  : width of the shared pair-phase counter
//   attempt_width(): width of the training attempt counter (must hold WORD_BITS)
// -----------------------------------------------------------------------------
package lane_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } align_state_t;

  localparam int unsigned WORD_BITS_MIN  = 4;
  localparam int unsigned WORD_BITS_MAX  = 16;
  localparam int unsigned SETTLE_CNT_W   = 3;

  function automatic int unsigned off_width(input int unsigned wb);
    return (wb > 1) ? $clog2(wb) : 1;
  endfunction

  function automatic int unsigned phase_width(input int unsigned wb);
    return (wb / 2 > 1) ? $clog2(wb / 2) : 1;
  endfunction

  function automatic int unsigned attempt_width(input int unsigned wb);
    return $clog2(wb + 1);
  endfunction

endpackage

// File: rtl/lane_word_gather.sv
// -----------------------------------------------------------------------------
// lane_word_gather
// One DDR lane: bit history, slip offset counter and window mux.
//   dco_clk, rst_n : clock / async active-low reset
//   i_rise, i_fall : bit pair for this edge (rise is the older bit)
//   i_emit         : capture a word on this edge
//   i_slip         : advance the offset by one bit (mod WORD_BITS)
//   o_word         : captured word, MSB = oldest bit
//   o_offset       : current slip offset
// -----------------------------------------------------------------------------
module lane_word_gather
  import lane_align_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int OFF_W     = off_width(WORD_BITS)
) (
  input  logic                 dco_clk,
  input  logic                 rst_n,
  input  logic                 i_rise,
  input  logic                 i_fall,
  input  logic                 i_emit,
  input  logic                 i_slip,
  output logic [WORD_BITS-1:0] o_word,
  output logic [OFF_W-1:0]     o_offset
);

  localparam int HIST_W = 2 * WORD_BITS;
  localparam int IDX_W  = $clog2(HIST_W);

  // The stored bits plus the pair arriving this edge form the full
  // 2*WORD_BITS history; the oldest pair would only ever be shifted out,
  // so it is not kept in the register.
  logic [HIST_W-3:0]    r_hist;
  logic [HIST_W-1:0]    w_win;
  logic [WORD_BITS-1:0] w_word;
  logic [WORD_BITS-1:0] r_word;
  logic [OFF_W-1:0]     r_offset;

  // Window position p lives at bit HIST_W-1-p (position 0 = oldest).
  assign w_win = {r_hist, i_rise, i_fall};

  // Select positions offset..offset+WORD_BITS-1, oldest bit into the MSB.
  always_comb begin
    w_word = '0;
    for (int j = 0; j < WORD_BITS; j++) begin
      w_word[WORD_BITS-1-j] = w_win[IDX_W'(HIST_W - 1 - j) - IDX_W'(r_offset)];
    end
  end

  // History shift, two bits per edge.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_win[HIST_W-3:0];
    end
  end

  // Slip offset; WORD_BITS need not be a power of two, so wrap explicitly.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset <= '0;
    end else if (i_slip) begin
      r_offset <= (r_offset == OFF_W'(WORD_BITS - 1)) ? '0 : r_offset + OFF_W'(1);
    end
  end

  // Word capture; the mux uses the registered offset, so a slip on an
  // emission edge only affects the following emission.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (i_emit) begin
      r_word <= w_word;
    end
  end

  assign o_word   = r_word;
  assign o_offset = r_offset;

endmodule

// File: rtl/lane_word_align.sv
// -----------------------------------------------------------------------------
// lane_word_align
// Deserialises LANES DDR lanes into WORD_BITS words and trains each lane's
// bit offset against TRAIN_PATTERN.
//   dco_clk, rst_n  : clock / async active-low reset
//   in_rise/in_fall : per-lane bit pair, rise is the earlier bit
//   bitslip_pulse   : manual one-bit slip per lane (only when not training)
//   train_start     : start (or restart) training
//   word_data       : aligned words, lane 0 in LSBs
//   word_valid      : one-cycle strobe per frame
//   lane_offset     : per-lane slip offset
//   lane_locked     : per-lane pattern match during training
//   align_busy/done/fail : training status
// -----------------------------------------------------------------------------
module lane_word_align
  import lane_align_pkg::*;
#(
  parameter int                   LANES         = 4,
  parameter int                   WORD_BITS     = 8,
  parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = WORD_BITS'(8'hF0),
  parameter int                   SETTLE_WORDS  = 1
) (
  input  logic                                 dco_clk,
  input  logic                                 rst_n,
  input  logic [LANES-1:0]                     in_rise,
  input  logic [LANES-1:0]                     in_fall,
  input  logic [LANES-1:0]                     bitslip_pulse,
  input  logic                                 train_start,
  output logic [LANES*WORD_BITS-1:0]           word_data,
  output logic                                 word_valid,
  output logic [LANES*off_width(WORD_BITS)-1:0] lane_offset,
  output logic [LANES-1:0]                     lane_locked,
  output logic                                 align_busy,
  output logic                                 align_done,
  output logic                                 align_fail
);

  localparam int OFF_W = off_width(WORD_BITS);
  localparam int PH_W  = phase_width(WORD_BITS);
  localparam int AT_W  = attempt_width(WORD_BITS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_BITS / 2 - 1);

  logic [PH_W-1:0]     r_phase;
  logic                w_emit;
  logic                r_word_valid;
  align_state_t        r_state, w_state_nxt;
  logic [LANES-1:0]    r_locked;
  logic [LANES-1:0]    w_match, w_lock_nxt, w_slip;
  logic [AT_W-1:0]     r_attempts, w_att_inc;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic                w_busy_now, w_busy_nxt, w_done_nxt, w_fail_nxt;
  logic                r_busy, r_done, r_fail;
  logic [LANES*WORD_BITS-1:0] w_word_bus;
  logic [LANES*OFF_W-1:0]     w_offset_bus;

  assign w_emit     = (r_phase == PH_LAST);
  assign w_busy_now = (r_state == ST_CHECK) || (r_state == ST_SETTLE);
  assign w_lock_nxt = r_locked | w_match;
  assign w_att_inc  = r_attempts + AT_W'(1);

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      lane_word_gather #(
        .WORD_BITS (WORD_BITS),
        .OFF_W     (OFF_W)
      ) u_gather (
        .dco_clk  (dco_clk),
        .rst_n    (rst_n),
        .i_rise   (in_rise[g]),
        .i_fall   (in_fall[g]),
        .i_emit   (w_emit),
        .i_slip   (w_slip[g]),
        .o_word   (w_word_bus[g*WORD_BITS +: WORD_BITS]),
        .o_offset (w_offset_bus[g*OFF_W +: OFF_W])
      );
      assign w_match[g] = (w_word_bus[g*WORD_BITS +: WORD_BITS] == TRAIN_PATTERN);
    end
  endgenerate

  // Shared pair-phase counter and frame strobe.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_phase      <= w_emit ? '0 : r_phase + PH_W'(1);
      r_word_valid <= w_emit;
    end
  end

  // Slip requests: training slips unmatched lanes on each compare; manual
  // slips apply only outside training and never disturb a locked lane.
  always_comb begin
    w_slip = '0;
    if ((r_state == ST_CHECK) && r_word_valid && !train_start) begin
      w_slip = ~w_lock_nxt;
    end else if (!w_busy_now) begin
      w_slip = bitslip_pulse & ~r_locked;
    end else begin
      w_slip = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (train_start) begin
      w_state_nxt = ST_CHECK;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_CHECK: begin
          if (!r_word_valid) begin
            w_state_nxt = ST_CHECK;
          end else if (&w_lock_nxt) begin
            w_state_nxt = ST_LOCKED;
          end else if (w_att_inc == AT_W'(WORD_BITS)) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (SETTLE_WORDS == 0) begin
            w_state_nxt = ST_CHECK;
          end else if (r_word_valid && (r_settle_cnt == SETTLE_CNT_W'(SETTLE_WORDS - 1))) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
        ST_LOCKED: w_state_nxt = ST_LOCKED;
        ST_FAIL:   w_state_nxt = ST_FAIL;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM output decode from the next state, so the flags are registered
  // and line up with the state they describe.
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_SETTLE);
    w_done_nxt = (w_state_nxt == ST_LOCKED);
    w_fail_nxt = (w_state_nxt == ST_FAIL);
  end

  // Status flag registers.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_fail <= w_fail_nxt;
    end
  end

  // Lock mask and attempt counter, updated on each compare in CHECK.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked   <= '0;
      r_attempts <= '0;
    end else if (train_start) begin
      r_locked   <= '0;
      r_attempts <= '0;
    end else if ((r_state == ST_CHECK) && r_word_valid) begin
      r_locked <= w_lock_nxt;
      if (!(&w_lock_nxt)) begin
        r_attempts <= w_att_inc;
      end
    end
  end

  // Counts discarded frames while settling after a slip.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
    end else if (r_state != ST_SETTLE) begin
      r_settle_cnt <= '0;
    end else if (r_word_valid) begin
      r_settle_cnt <= r_settle_cnt + SETTLE_CNT_W'(1);
    end
  end

  assign word_data   = w_word_bus;
  assign word_valid  = r_word_valid;
  assign lane_offset = w_offset_bus;
  assign lane_locked = r_locked;
  assign align_busy  = r_busy;
  assign align_done  = r_done;
  assign align_fail  = r_fail;

endmodule

// File: doc/lane_word_align.md
LANE_WORD_ALIGN -- requirements
Module: lane_word_align

Interface
REQ-001 SHALL have parameter LANES, default 4: number of DDR data lanes, 1..16.
REQ-002 SHALL have parameter WORD_BITS, default 8: deserialised word width, even, 4..16.
REQ-003 SHALL have parameter TRAIN_PATTERN, default 8'hF0 (WORD_BITS wide): expected frame word during training.
REQ-004 SHALL have parameter SETTLE_WORDS, default 1: words discarded after a slip before the next compare, 0..7.
REQ-005 SHALL have one clock and an asynchronous active-low reset. Ports, clock and reset first:
  dco_clk  in  1  sole clock, rising edge only
  rst_n  in  1  asynchronous active-low reset
  in_rise  in  LANES  rise-phase bit per lane; earlier bit of each pair
  in_fall  in  LANES  fall-phase bit per lane; later bit of each pair
  bitslip_pulse  in  LANES  manual one-bit slip request per lane
  train_start  in  1  start-training pulse
  word_data  out  LANES*WORD_BITS  aligned words, lane 0 in LSBs, MSB = oldest bit
  word_valid  out  1  one-cycle strobe per frame
  lane_offset  out  LANES*$clog2(WORD_BITS)  current slip offset per lane
  lane_locked  out  LANES  lane matched TRAIN_PATTERN
  align_busy  out  1  training in progress
  align_done  out  1  all lanes locked
  align_fail  out  1  training gave up

Function
REQ-006 SHALL form a serial stream per lane: in_rise, then in_fall, per dco_clk edge.
REQ-007 SHALL keep a 2*WORD_BITS-bit history per lane, shifting in 2 bits every edge.
REQ-008 SHALL run a shared phase counter 0..WORD_BITS/2-1, wrapping, starting at 0 after reset release.
REQ-009 On the edge where phase = WORD_BITS/2-1, SHALL register per lane the WORD_BITS bits at positions offset..offset+WORD_BITS-1 of the 2*WORD_BITS window including the pair sampled on that edge (position 0 = oldest), and SHALL pulse word_valid for the following cycle.
REQ-010 word_valid SHALL never assert on consecutive cycles when WORD_BITS > 2; word_data SHALL hold between strobes.
REQ-011 bitslip_pulse[i] SHALL increment lane_offset[i] by 1, modulo WORD_BITS (WORD_BITS-1 wraps to 0), when align_busy = 0.
REQ-012 bitslip_pulse SHALL be ignored while align_busy = 1.
REQ-013 An offset change on an emission edge SHALL take effect from the next emission; the current emission SHALL use the old offset.
REQ-014 Training FSM states: IDLE, CHECK, SETTLE, LOCKED, FAIL.
REQ-015 train_start in any state SHALL enter CHECK, clear lane_locked, zero the attempt counter and clear align_done/align_fail.
REQ-016 In CHECK, on each word_valid, every unlocked lane whose word equals TRAIN_PATTERN SHALL set lane_locked; every other unlocked lane SHALL increment its offset by 1.
REQ-017 If all lanes are then locked, SHALL go to LOCKED and set align_done; otherwise SHALL increment attempts.
REQ-018 If attempts reach WORD_BITS, SHALL go to FAIL and set align_fail; otherwise SHALL go to SETTLE.
REQ-019 SETTLE SHALL count SETTLE_WORDS word_valid strobes, then return to CHECK; with SETTLE_WORDS = 0 it SHALL return on the next cycle.
REQ-020 align_busy SHALL be 1 exactly in CHECK and SETTLE.
REQ-021 Locked lanes SHALL keep their offset until the next train_start or reset.

Reset
REQ-022 While rst_n = 0, all outputs SHALL be 0; history, offsets, phase and attempts SHALL be 0; FSM SHALL be IDLE.
REQ-023 Reset asserted mid-training SHALL abort to IDLE with no partial lock retained.

Structure
REQ-024 Package lane_align_pkg SHALL hold the FSM state enum and WORD_BITS/offset-width helper constants.
REQ-025 Per-lane logic (history, offset counter, window mux) SHALL live in sub-module lane_word_gather, instantiated LANES times.

Verification
REQ-026 LANES=2, WORD_BITS=8, offsets 0, stream 8'hA5 repeated -> word_valid every 4th cycle, word_data = {8'hA5, 8'hA5}.
REQ-027 One bitslip_pulse on lane 1 -> from the next emission lane 1 = 8'h4B (rotated by 1), lane 0 unchanged, lane_offset[1] = 1.
REQ-028 Eight pulses on lane 0 -> lane_offset[0] wraps to 0 and the word returns to 8'hA5.
REQ-029 Stream 8'hF0, lane 0 pre-offset 0, lane 1 delayed 3 bits, train_start -> lane 0 locks on the first compare, lane 1 locks with offset 3, align_done = 1, align_busy = 0.
REQ-030 Stream 8'hFF, train_start -> align_fail = 1 after 8 attempts, lane_locked = 0; rst_n pulsed mid-training -> all outputs 0, state IDLE.
